// File: rtl/encoder_sys.sv
// encoder_sys: rate-1/2 feedforward convolutional encoder with selectable
// constraint length (K = 3..6) and a zero-tail termination of every frame.
//
// Ports:
//   clk                      system clock, all logic on its rising edge
//   rst                      synchronous active-high reset
//   choose_constraint_length K select, latched on the first bit of a frame
//   in_valid / in_ready      input handshake for in_bit / in_last
//   in_bit                   information bit u
//   in_last                  last information bit of the frame
//   out_valid / out_ready    output handshake for encoded_bits / out_last
//   encoded_bits             [1] = G0 parity, [0] = G1 parity
//   out_last                 final tail symbol of the frame
//   busy                     FSM is not IDLE
module encoder_sys (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] choose_constraint_length,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] encoded_bits,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_e;

  state_e     state_q, state_d;
  logic [4:0] sr_q, sr_d;
  logic [2:0] k_q, k_d;
  logic [2:0] tail_cnt_q, tail_cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] enc_q, enc_d;
  logic       last_q, last_d;

  logic [2:0] k_in;
  logic [2:0] k_use;
  logic       slot_free;
  logic       accept;
  logic       inject;
  logic       final_taken;
  logic       u;
  logic [5:0] g0;
  logic [5:0] g1;
  logic [5:0] taps;
  logic [1:0] parity;

  // Out-of-range K selections fall back to K=3.
  always_comb begin
    k_in = choose_constraint_length;
    if (choose_constraint_length < 3'd3 || choose_constraint_length == 3'd7) begin
      k_in = 3'd3;
    end
  end

  // The first bit of a frame is encoded with the K being latched on that same edge.
  assign k_use = (state_q == IDLE) ? k_in : k_q;

  // Generators are stored left-aligned in 6 bits so that bit 5 always taps u,
  // bit 4 taps sr[0], and so on; unused low bits are zero for shorter K.
  always_comb begin
    case (k_use)
      3'd4:    begin g0 = 6'b110100; g1 = 6'b111100; end
      3'd5:    begin g0 = 6'b100110; g1 = 6'b111010; end
      3'd6:    begin g0 = 6'b101011; g1 = 6'b111101; end
      default: begin g0 = 6'b111000; g1 = 6'b101000; end
    endcase
  end

  assign slot_free   = !out_valid_q || out_ready;
  assign in_ready    = !rst && (state_q != TAIL) && slot_free;
  assign accept      = in_valid && in_ready;
  assign inject      = (state_q == TAIL) && slot_free && (tail_cnt_q != 3'd0);
  assign final_taken = out_valid_q && last_q && out_ready;

  // Tail symbols always shift in a zero.
  assign u      = accept ? in_bit : 1'b0;
  assign taps   = {u, sr_q[0], sr_q[1], sr_q[2], sr_q[3], sr_q[4]};
  assign parity = {^(g0 & taps), ^(g1 & taps)};

  // Next-state logic for the FSM, shift register, tail counter and output slot.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    k_d         = k_q;
    tail_cnt_d  = tail_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    enc_d       = enc_q;
    last_d      = last_q;

    if (accept || inject) begin
      out_valid_d = 1'b1;
      enc_d       = parity;
      sr_d        = {sr_q[3:0], u};
      last_d      = inject && (tail_cnt_q == 3'd1);
    end

    if (accept) begin
      if (state_q == IDLE) begin
        k_d = k_in;
      end
      if (in_last) begin
        state_d    = TAIL;
        tail_cnt_d = k_use - 3'd1;
      end else begin
        state_d = DATA;
      end
    end

    if (inject) begin
      tail_cnt_d = tail_cnt_q - 3'd1;
    end

    // Clearing sr here also wipes stale high bits left over from a short K.
    if (state_q == TAIL && final_taken) begin
      state_d = IDLE;
      sr_d    = 5'd0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= 5'd0;
      k_q         <= 3'd3;
      tail_cnt_q  <= 3'd0;
      out_valid_q <= 1'b0;
      enc_q       <= 2'b00;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      k_q         <= k_d;
      tail_cnt_q  <= tail_cnt_d;
      out_valid_q <= out_valid_d;
      enc_q       <= enc_d;
      last_q      <= last_d;
    end
  end

  // Outputs are forced idle for as long as rst is held, not just after the edge.
  assign out_valid    = !rst && out_valid_q;
  assign encoded_bits = rst ? 2'b00 : enc_q;
  assign out_last     = !rst && out_valid_q && last_q;
  assign busy         = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_encoder_sys.sv
// tb_encoder_sys: directed and randomised frames against a behavioural
// convolutional encoder model feeding a scoreboard of {out_last, G0, G1}.
module tb_encoder_sys;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] choose_constraint_length;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] encoded_bits;
  logic       out_last;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  // Expected symbols: bit 2 = out_last, bits 1:0 = encoded_bits.
  logic [2:0] sb[$];
  logic [4:0] mSr;
  int         mK;

  encoder_sys dut (
    .clk                      (clk),
    .rst                      (rst),
    .choose_constraint_length (choose_constraint_length),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .in_bit                   (in_bit),
    .in_last                  (in_last),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .encoded_bits             (encoded_bits),
    .out_last                 (out_last),
    .busy                     (busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int mapK(input logic [2:0] c);
    if (c >= 3'd3 && c <= 3'd6) return int'(c);
    return 3;
  endfunction

  // Direct reading of the tap rule: g[K-1] taps u, g[K-2-j] taps sr[j].
  function automatic logic [1:0] encModel(input int k, input logic [4:0] sr, input logic u);
    logic [5:0] g0;
    logic [5:0] g1;
    logic       p0;
    logic       p1;
    logic       b;
    case (k)
      4:       begin g0 = 6'o15; g1 = 6'o17; end
      5:       begin g0 = 6'o23; g1 = 6'o35; end
      6:       begin g0 = 6'o53; g1 = 6'o75; end
      default: begin g0 = 6'o07; g1 = 6'o05; end
    endcase
    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (i == k - 1) b = u;
      else            b = sr[k - 2 - i];
      p0 = p0 ^ (g0[i] & b);
      p1 = p1 ^ (g1[i] & b);
    end
    return {p0, p1};
  endfunction

  // Model reaction to one accepted input bit; the whole tail is queued on in_last.
  function automatic void modelAccept(input bit first, input logic [2:0] kSel, input logic u, input logic last);
    if (first) mK = mapK(kSel);
    sb.push_back({1'b0, encModel(mK, mSr, u)});
    mSr = {mSr[3:0], u};
    if (last) begin
      for (int t = 1; t < mK; t++) begin
        sb.push_back({(t == mK - 1), encModel(mK, mSr, 1'b0)});
        mSr = {mSr[3:0], 1'b0};
      end
      mSr = 5'd0;
    end
  endfunction

  // Drive one frame (bit idx at bits[idx]) and check every output cycle.
  // Entered and left at 1 ns after a rising edge.
  task automatic applyStimulus(input logic [15:0] bits, input int n, input logic [2:0] k,
                               input logic [2:0] kMid, input int stallAfter, input int stallLen,
                               input bit holdValid, input bit abortTail);
    int idx = 0;
    int cyc = 0;
    bit done = 1'b0;
    while (!done) begin
      in_valid  = (idx < n) || holdValid;
      in_bit    = (idx < n) ? bits[idx] : 1'b1;
      in_last   = (idx == n - 1);
      choose_constraint_length = (idx == 0) ? k : kMid;
      out_ready = !(cyc >= stallAfter && cyc < stallAfter + stallLen);
      @(negedge clk);
      if (cyc == 0) checkOutput("inReadyStart", {7'b0, in_ready}, 8'd1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spuriousValid", {7'b0, out_valid}, 8'd0);
        end else begin
          checkOutput("symbol", {5'b0, out_last, encoded_bits}, {5'b0, sb[0]});
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (out_valid && !out_ready) checkOutput("stallInReady", {7'b0, in_ready}, 8'd0);
      if (idx >= n) checkOutput("tailInReady", {7'b0, in_ready}, 8'd0);
      if (in_valid && in_ready && idx < n) begin
        modelAccept(idx == 0, choose_constraint_length, in_bit, in_last);
        idx++;
      end
      if (idx >= n && (abortTail || sb.size() == 0)) done = 1'b1;
      cyc++;
      if (!done && cyc > 300) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL timeout: frame not drained, %0d symbols pending, expected 0", sb.size());
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Linear sequence of directed scenarios followed by a few random frames.
  initial begin
    logic [15:0] rbits;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bit = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    choose_constraint_length = 3'd3;
    mSr = 5'd0;
    mK = 3;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("resetOutputs", {3'b0, out_valid, in_ready, out_last, encoded_bits}, 8'd0);
    checkOutput("resetBusy", {7'b0, busy}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // K=3 frame 1,0,1,1 -> 11,10,00,01,01,11
    applyStimulus(16'b1101, 4, 3'd3, 3'd3, 0, 0, 1'b0, 1'b0);

    // K=6 impulse -> 11,01,11,01,10,11 and busy drops afterwards
    applyStimulus(16'b1, 1, 3'd6, 3'd6, 0, 0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("busyFall", {7'b0, busy}, 8'd0);
    @(posedge clk);
    #1;

    // K=3 frame with a 3-cycle downstream stall mid-frame
    applyStimulus(16'b101101, 6, 3'd3, 3'd3, 3, 3, 1'b0, 1'b0);

    // K latched at 4, switched to 6 mid-frame: 3 tail symbols
    applyStimulus(16'b101101, 6, 3'd4, 3'd6, 0, 0, 1'b0, 1'b0);

    // K=7 selects the K=3 code; K=5 frame for coverage of that generator pair
    applyStimulus(16'b0111, 4, 3'd7, 3'd5, 0, 0, 1'b0, 1'b0);
    applyStimulus(16'b10011, 5, 3'd5, 3'd5, 0, 0, 1'b0, 1'b0);

    // Reset while the frame is in its tail
    applyStimulus(16'b011, 3, 3'd5, 3'd5, 0, 0, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMidTail", {3'b0, out_valid, in_ready, out_last, encoded_bits}, 8'd0);
    checkOutput("rstBusy", {7'b0, busy}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mSr = 5'd0;
    @(negedge clk);
    checkOutput("postRstValid", {7'b0, out_valid}, 8'd0);
    checkOutput("postRstReady", {7'b0, in_ready}, 8'd1);
    @(posedge clk);
    #1;
    applyStimulus(16'b1101, 4, 3'd3, 3'd3, 0, 0, 1'b0, 1'b0);

    // Back-to-back frames with in_valid held high across the boundary
    applyStimulus(16'b11010, 5, 3'd5, 3'd5, 0, 0, 1'b1, 1'b0);
    applyStimulus(16'b1101, 4, 3'd3, 3'd3, 0, 0, 1'b0, 1'b0);

    // Random frames with random K and stalls
    for (int f = 0; f < 6; f++) begin
      rbits = 16'($urandom);
      applyStimulus(rbits, int'($urandom_range(1, 12)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end

    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("finalIdle", {6'b0, busy, out_valid}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
